receive: RTL and testbench
==========================

// Module: receive
//
// PURPOSE
// - Receiving end of the instruction-load link. Requests a word stream with r_o_syn,
//   captures every word the sender flags with ack into an internal instruction buffer,
//   and stops on the word flagged last.
// - Sits between the instruction source (transmit) and the fetch stage. The fetch stage
//   reads the loaded program through a synchronous read port once r_o_done is high.
//
// PARAMETERS
// - IWIDTH   32   instruction word width; must match the sender's `IWIDTH.
// - DEPTH    64   buffer capacity in words; power of two, >= 2.
// - AWIDTH   6    address width, $clog2(DEPTH).
// - TIMEOUT  16   max consecutive syn-high cycles without ack before abort; >= 1.
//
// PORTS
// - r_clk         in   1       clock, all state on rising edge
// - r_rst         in   1       asynchronous reset, active-low
// - r_i_start     in   1       1-cycle pulse: begin a load (honoured in IDLE/DONE/ERR only)
// - r_o_syn       out  1       request to sender; high while receiving
// - r_i_instr     in   IWIDTH  word from sender, valid when r_i_ack=1
// - r_i_last      in   1       marks final word, valid when r_i_ack=1
// - r_i_ack       in   1       sender qualifies r_i_instr/r_i_last this cycle
// - r_i_rd_addr   in   AWIDTH  fetch-side read address
// - r_o_rd_instr  out  IWIDTH  buffer[r_i_rd_addr], 1-cycle latency
// - r_o_count     out  AWIDTH+1  words captured in current/last load
// - r_o_done      out  1       load finished cleanly (sticky until next start/reset)
// - r_o_err       out  1       load aborted: overflow or timeout (sticky)
// - r_o_busy      out  1       high in REQ/RECV
//
// BEHAVIOUR
// - Reset (r_rst=0, async): state IDLE; r_o_syn, r_o_done, r_o_err, r_o_busy = 0;
//   r_o_count = 0; wr pointer = 0; timeout counter = 0; r_o_rd_instr = 0. Buffer
//   contents are not cleared.
// - States: IDLE, REQ, RECV, DONE, ERR. r_o_syn = r_o_busy = (state==REQ||state==RECV), registered.
// - IDLE/DONE/ERR + r_i_start -> REQ; clears done, err, count, wr pointer, timeout counter.
// - REQ: syn high. No ack -> timeout counter +1. Ack -> capture and enter RECV.
// - Capture rule (REQ/RECV, r_i_ack=1): buffer[wr_ptr] <= r_i_instr; wr_ptr+1;
//   r_o_count+1; timeout counter cleared. One word per acked cycle; back-to-back ack
//   accepted every cycle.
// - Capture with r_i_last=1 -> DONE next cycle: r_o_done=1, syn drops.
//   Any ack seen after syn has dropped is ignored.
// - Overflow: ack while count==DEPTH (buffer full) -> word discarded, ERR, r_o_err=1.
//   Filling exactly DEPTH words with last on word DEPTH -> DONE, not ERR.
// - Timeout: counter reaches TIMEOUT with no ack -> ERR. TIMEOUT=16 means the 16th
//   consecutive unacked syn cycle aborts.
// - r_i_start while REQ/RECV is ignored. Ack while IDLE/DONE/ERR is ignored.
// - Reset mid-load: immediate return to IDLE, syn low; partial words remain in the
//   buffer but count=0.
// - Read port: r_o_rd_instr <= buffer[r_i_rd_addr] every cycle, in any state.
//   Read-during-write to the same address returns the old word.
// - Count width is AWIDTH+1 so the value DEPTH is representable.
//
// CONFIGURATION
// - RECV_CHECKSUM_EN defined: adds output r_o_csum [IWIDTH-1:0], the XOR of all words
//   captured in the current load. Cleared on reset and on start, updated on each capture,
//   held in DONE/ERR.
// - RECV_CHECKSUM_EN undefined: port and logic absent. All other behaviour is identical.
//
// TESTING
// - Reset 2 cycles, then start; sender acks 0x20080005, 0x20090003, 0x01095020 (last)
//   -> count=3, done=1, err=0, syn low 1 cycle after last; read addr 0..2 returns the words.
// - Start; sender holds ack low for 16 cycles -> err=1, done=0, syn low, count=0.
// - DEPTH=4: sender acks 5 words with no last -> first 4 stored, 5th discarded; err=1, count=4.
// - Start; 2 words acked, r_rst pulsed low for 1 cycle -> IDLE, syn=0, count=0; new start
//   reloads from addr 0.
// - Start during RECV and ack after DONE -> both ignored; count unchanged, done stays 1.
// - RECV_CHECKSUM_EN: load 0x0000000F, 0x000000F0 (last) -> r_o_csum=0x000000FF.

Source files
------------

// File: rtl/receive.sv
// receive: receiving end of the instruction-load link, with a synchronous-read instruction buffer.
// Optional XOR checksum of the captured words is enabled with `define RECV_CHECKSUM_EN.
module receive #(
    parameter int IWIDTH  = 32,
    parameter int DEPTH   = 64,
    parameter int AWIDTH  = 6,
    parameter int TIMEOUT = 16
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              r_i_start,
    output logic              r_o_syn,
    input  logic [IWIDTH-1:0] r_i_instr,
    input  logic              r_i_last,
    input  logic              r_i_ack,
    input  logic [AWIDTH-1:0] r_i_rd_addr,
    output logic [IWIDTH-1:0] r_o_rd_instr,
    output logic [AWIDTH:0]   r_o_count,
    output logic              r_o_done,
    output logic              r_o_err,
    output logic              r_o_busy
`ifdef RECV_CHECKSUM_EN
    ,
    output logic [IWIDTH-1:0] r_o_csum
`endif
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AWIDTH:0] CNT_FULL = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] CNT_ONE  = (AWIDTH + 1)'(1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   TMO_ONE  = TW'(1);

    typedef enum logic [2:0] {IDLE, REQ, RECV, DONE, ERR} state_t;

    state_t            state_reg, state_next;
    logic [AWIDTH:0]   count_reg, count_next;
    logic [TW-1:0]     tmo_reg, tmo_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              syn_reg, syn_next;
    logic              wr_en;
    logic [AWIDTH-1:0] wr_ptr;
    logic [IWIDTH-1:0] rd_reg;
    logic [IWIDTH-1:0] mem [DEPTH];
`ifdef RECV_CHECKSUM_EN
    logic [IWIDTH-1:0] csum_reg, csum_next;
`endif

    // The write pointer is always the low bits of the word count.
    assign wr_ptr = count_reg[AWIDTH-1:0];

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            tmo_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            syn_reg   <= 1'b0;
`ifdef RECV_CHECKSUM_EN
            csum_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            tmo_reg   <= tmo_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            syn_reg   <= syn_next;
`ifdef RECV_CHECKSUM_EN
            csum_reg  <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        tmo_next   = tmo_reg;
        done_next  = done_reg;
        err_next   = err_reg;
        wr_en      = 1'b0;
`ifdef RECV_CHECKSUM_EN
        csum_next  = csum_reg;
`endif
        case (state_reg)
            REQ, RECV: begin
                if (r_i_ack) begin
                    if (count_reg == CNT_FULL) begin
                        state_next = ERR;
                        err_next   = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        count_next = count_reg + CNT_ONE;
                        tmo_next   = '0;
`ifdef RECV_CHECKSUM_EN
                        csum_next  = csum_reg ^ r_i_instr;
`endif
                        if (r_i_last) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = RECV;
                        end
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    state_next = ERR;
                    err_next   = 1'b1;
                end else begin
                    tmo_next = tmo_reg + TMO_ONE;
                end
            end
            default: begin
                if (r_i_start) begin
                    state_next = REQ;
                    count_next = '0;
                    tmo_next   = '0;
                    done_next  = 1'b0;
                    err_next   = 1'b0;
`ifdef RECV_CHECKSUM_EN
                    csum_next  = '0;
`endif
                end
            end
        endcase
        syn_next = (state_next == REQ) || (state_next == RECV);
    end

    // Buffer contents survive reset, so the write port carries no reset.
    always_ff @(posedge r_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= r_i_instr;
        end
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            rd_reg <= '0;
        end else begin
            rd_reg <= mem[r_i_rd_addr];
        end
    end

    assign r_o_syn      = syn_reg;
    assign r_o_busy     = syn_reg;
    assign r_o_count    = count_reg;
    assign r_o_done     = done_reg;
    assign r_o_err      = err_reg;
    assign r_o_rd_instr = rd_reg;
`ifdef RECV_CHECKSUM_EN
    assign r_o_csum     = csum_reg;
`endif

endmodule

// File: tb/tb_receive.sv
// Scoreboard bench for receive: a 64-deep and a 4-deep instance share the link inputs,
// load outcomes and buffer reads are predicted from a word-list model and checked by a monitor.
module tb_receive;

    localparam int TMO = 16;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic        start0, start1, ack, last, rd_req, rd_req_q;
    logic [31:0] instr;
    logic [5:0]  rd_addr;

    logic        syn0, done0, err0, busy0;
    logic [31:0] rd0;
    logic [6:0]  count0;
    logic        syn1, done1, err1, busy1;
    logic [31:0] rd1;
    logic [2:0]  count1;
`ifdef RECV_CHECKSUM_EN
    logic [31:0] csum0, csum1;
`endif

    always #5 r_clk = ~r_clk;

    receive #(.IWIDTH(32), .DEPTH(64), .AWIDTH(6), .TIMEOUT(TMO)) dut (
        .r_clk(r_clk), .r_rst(r_rst), .r_i_start(start0), .r_o_syn(syn0),
        .r_i_instr(instr), .r_i_last(last), .r_i_ack(ack), .r_i_rd_addr(rd_addr),
        .r_o_rd_instr(rd0), .r_o_count(count0), .r_o_done(done0), .r_o_err(err0),
        .r_o_busy(busy0)
`ifdef RECV_CHECKSUM_EN
        , .r_o_csum(csum0)
`endif
    );

    receive #(.IWIDTH(32), .DEPTH(4), .AWIDTH(2), .TIMEOUT(TMO)) dut4 (
        .r_clk(r_clk), .r_rst(r_rst), .r_i_start(start1), .r_o_syn(syn1),
        .r_i_instr(instr), .r_i_last(last), .r_i_ack(ack), .r_i_rd_addr(rd_addr[1:0]),
        .r_o_rd_instr(rd1), .r_o_count(count1), .r_o_done(done1), .r_o_err(err1),
        .r_o_busy(busy1)
`ifdef RECV_CHECKSUM_EN
        , .r_o_csum(csum1)
`endif
    );

    typedef struct {int cnt; bit done; bit err; logic [31:0] csum;} res_t;
    typedef struct {int sel; int addr; logic [31:0] data;} rd_t;

    res_t res_q0[$];
    res_t res_q1[$];
    rd_t  rd_q[$];

    logic [31:0] mem0 [64];
    bit          known0 [64];
    logic [31:0] mem1 [4];
    bit          known1 [4];

    logic [31:0] lw[$];
    int          lg[$];
    int          llast;
    bit          lmid;

    int total = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(posedge r_clk) rd_req_q <= rd_req;

    // Monitor: compares a load outcome when done/err rises, and read data one cycle after a request.
    initial begin
        bit prev0 = 1'b0;
        bit prev1 = 1'b0;
        res_t r;
        rd_t  q;
        forever begin
            @(negedge r_clk);
            if ((done0 | err0) === 1'b1 && !prev0) begin
                check("res0_avail", res_q0.size() > 0, 1);
                if (res_q0.size() > 0) begin
                    r = res_q0.pop_front();
                    $display("load dut64: count=%0d done=%0b err=%0b (model %0d/%0b/%0b)",
                             count0, done0, err0, r.cnt, r.done, r.err);
                    check("count64", count0, r.cnt);
                    check("done64", done0, r.done);
                    check("err64", err0, r.err);
                    check("syn64_low", syn0, 0);
                    check("busy64_low", busy0, 0);
`ifdef RECV_CHECKSUM_EN
                    check("csum64", csum0, r.csum);
`endif
                end
            end
            if ((done1 | err1) === 1'b1 && !prev1) begin
                check("res4_avail", res_q1.size() > 0, 1);
                if (res_q1.size() > 0) begin
                    r = res_q1.pop_front();
                    $display("load dut4: count=%0d done=%0b err=%0b (model %0d/%0b/%0b)",
                             count1, done1, err1, r.cnt, r.done, r.err);
                    check("count4", count1, r.cnt);
                    check("done4", done1, r.done);
                    check("err4", err1, r.err);
                    check("syn4_low", syn1, 0);
`ifdef RECV_CHECKSUM_EN
                    check("csum4", csum1, r.csum);
`endif
                end
            end
            prev0 = ((done0 | err0) === 1'b1);
            prev1 = ((done1 | err1) === 1'b1);
            if (rd_req_q === 1'b1) begin
                check("rd_avail", rd_q.size() > 0, 1);
                if (rd_q.size() > 0) begin
                    q = rd_q.pop_front();
                    $display("read dut%0d addr=%0d data=0x%08h", q.sel ? 4 : 64, q.addr,
                             q.sel ? rd1 : rd0);
                    check(q.sel ? "rd4" : "rd64", q.sel ? rd1 : rd0, q.data);
                end
            end
        end
    end

    // Model: walk the word list with the link rules, then drive the same list onto the link.
    task automatic run_load(input int sel);
        int depth = sel ? 4 : 64;
        int cnt = 0;
        int k = 0;
        bit stop = 1'b0;
        res_t r;
        r.done = 1'b0;
        r.err  = 1'b0;
        r.csum = '0;
        for (int i = 0; i < lw.size() && !stop; i++) begin
            if (lg[i] >= TMO || cnt == depth) begin
                r.err = 1'b1;
                stop = 1'b1;
            end else begin
                if (sel) begin mem1[cnt] = lw[i]; known1[cnt] = 1'b1; end
                else begin mem0[cnt] = lw[i]; known0[cnt] = 1'b1; end
                cnt++;
                r.csum ^= lw[i];
                if (i == llast) begin
                    r.done = 1'b1;
                    stop = 1'b1;
                end
            end
        end
        if (!stop) r.err = 1'b1;
        r.cnt = cnt;
        if (sel) res_q1.push_back(r); else res_q0.push_back(r);

        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge r_clk);
        start0 = 1'b0;
        start1 = 1'b0;
        for (int i = 0; i < lw.size(); i++) begin
            ack = 1'b0;
            repeat (lg[i]) @(negedge r_clk);
            ack   = 1'b1;
            instr = lw[i];
            last  = (i == llast);
            if (lmid && i == 1) begin
                if (sel) start1 = 1'b1; else start0 = 1'b1;
            end
            @(negedge r_clk);
            ack    = 1'b0;
            last   = 1'b0;
            start0 = 1'b0;
            start1 = 1'b0;
        end
        while (!((sel ? (done1 | err1) : (done0 | err0)) === 1'b1) && k < 100) begin
            @(negedge r_clk);
            k++;
        end
        check("load_wait", k < 100, 1);
        @(negedge r_clk);
    endtask

    task automatic do_read(input int sel, input int addr);
        rd_t q;
        if (!(sel ? known1[addr] : known0[addr])) return;
        q.sel  = sel;
        q.addr = addr;
        q.data = sel ? mem1[addr] : mem0[addr];
        rd_q.push_back(q);
        rd_addr = 6'(addr);
        rd_req  = 1'b1;
        @(negedge r_clk);
        rd_req  = 1'b0;
    endtask

    task automatic set_load(input int n, input int gmax, input int lst);
        lw.delete();
        lg.delete();
        for (int i = 0; i < n; i++) begin
            lw.push_back($urandom);
            lg.push_back($urandom_range(0, gmax));
        end
        llast = lst;
        lmid  = 1'b0;
    endtask

    initial begin
        r_rst = 1'b1; start0 = 0; start1 = 0; ack = 0; last = 0; instr = '0;
        rd_addr = '0; rd_req = 0;
        #2 r_rst = 1'b0;
        repeat (2) @(negedge r_clk);
        check("rst_syn", syn0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_count", count0, 0);
        check("rst_rd", rd0, 0);
        check("rst_count4", count1, 0);
        r_rst = 1'b1;
        @(negedge r_clk);

        // Directed three-word program.
        lw = '{32'h20080005, 32'h20090003, 32'h01095020};
        lg = '{0, 0, 0};
        llast = 2; lmid = 0;
        run_load(0);
        for (int a = 0; a < 3; a++) do_read(0, a);

        // Pure timeout, then gaps just below and exactly at the limit.
        lw.delete(); lg.delete(); llast = -1;
        run_load(0);
        lw = '{32'h11111111, 32'h22222222}; lg = '{15, 15}; llast = 1;
        run_load(0);
        lw = '{32'h33333333, 32'h44444444}; lg = '{0, 16}; llast = 1;
        run_load(0);

        // Small buffer: overflow on the fifth word, then an exact fill ending in last.
        set_load(5, 0, -1);
        run_load(1);
        for (int a = 0; a < 4; a++) do_read(1, a);
        set_load(4, 1, 3);
        run_load(1);
        for (int a = 0; a < 4; a++) do_read(1, a);

        // Long load to populate the buffer, then random loads.
        set_load(10, 3, 9);
        run_load(0);
        for (int a = 0; a < 10; a++) do_read(0, a);
        for (int t = 0; t < 16; t++) begin
            int sel = $urandom_range(0, 1);
            int n = $urandom_range(1, sel ? 6 : 12);
            set_load(n, 2, ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, n - 1));
            for (int i = 0; i < n; i++)
                if ($urandom_range(0, 9) == 0) lg[i] = $urandom_range(14, 17);
            run_load(sel);
            for (int j = 0; j < 3; j++) do_read(sel, $urandom_range(0, sel ? 3 : 11));
        end

        // Start during RECV and acks after DONE must both be ignored.
        lw = '{32'hA0000001, 32'hA0000002, 32'hA0000003}; lg = '{0, 1, 0};
        llast = 2; lmid = 1;
        run_load(0);
        lmid = 0;
        for (int i = 0; i < 3; i++) begin
            ack = 1'b1; instr = 32'hDEAD0000 + 32'(i); last = (i == 2);
            @(negedge r_clk);
        end
        ack = 1'b0; last = 1'b0;
        @(negedge r_clk);
        check("ign_count", count0, 3);
        check("ign_done", done0, 1);
        check("ign_err", err0, 0);
        check("ign_syn", syn0, 0);
        for (int a = 0; a < 6; a++) do_read(0, a);

        // Reset in the middle of a load.
        start0 = 1'b1;
        @(negedge r_clk);
        start0 = 1'b0; ack = 1'b1; instr = 32'hB0000000;
        mem0[0] = 32'hB0000000; known0[0] = 1'b1;
        @(negedge r_clk);
        instr = 32'hB0000001;
        mem0[1] = 32'hB0000001; known0[1] = 1'b1;
        @(negedge r_clk);
        ack = 1'b0; r_rst = 1'b0;
        #1;
        check("mid_rst_syn", syn0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_count", count0, 0);
        check("mid_rst_done", done0, 0);
        @(negedge r_clk);
        r_rst = 1'b1;
        @(negedge r_clk);
        do_read(0, 1);
        lw = '{32'hC0000000, 32'hC0000001, 32'hC0000002}; lg = '{0, 0, 2}; llast = 2;
        run_load(0);
        for (int a = 0; a < 4; a++) do_read(0, a);

        // Checksum pattern.
        lw = '{32'h0000000F, 32'h000000F0}; lg = '{0, 0}; llast = 1;
        run_load(0);

        repeat (4) @(negedge r_clk);
        check("res0_drained", res_q0.size(), 0);
        check("res4_drained", res_q1.size(), 0);
        check("rd_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
